mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters (name, default, meaning): PADDR_W, 20, physical address width (pptr_t).
REQ-002 LINE_W, 128, cacheline width (cacheline_t); OFFSET_W = log2(LINE_W/8).
REQ-003 MEM_LINES, 256, lines of backing storage; index = addr[OFFSET_W +: log2(MEM_LINES)], upper bits alias.
REQ-004 MEM_LATENCY, 5, minimum cycles from request acceptance to response; legal range 1..15.
REQ-005 QUEUE_DEPTH, 4, outstanding-read queue entries; power of two.
REQ-006 Ports (name, direction, width, meaning): clk, in, 1, single clock, all state on rising edge.
REQ-007 rst, in, 1, asynchronous active-low reset.
REQ-008 ireq_ren, in, 1, instruction-side read request, one-cycle pulse.
REQ-009 ireq_addr, in, PADDR_W, instruction-side request address.
REQ-010 dreq_ren, in, 1, data-side read request, one-cycle pulse.
REQ-011 dreq_wen, in, 1, data-side line write, one-cycle pulse; never asserted together with dreq_ren.
REQ-012 dreq_addr, in, PADDR_W, data-side address; dreq_wdata, in, LINE_W, write line.
REQ-013 rec_en, out, 1, response valid for one cycle.
REQ-014 rec_addr, out, PADDR_W, line-aligned address of response (offset bits zero).
REQ-015 rec_cacheline, out, LINE_W, returned line; rec_dst, out, 1, 0 = instruction side, 1 = data side.
REQ-016 queue_full, out, 1, no free entry this cycle; drop_count, out, 8, saturating count of dropped requests.

Function
REQ-017 Read requests SHALL be accepted in the cycle they are asserted, with no ready/backpressure; line data SHALL be sampled from storage at acceptance and held in the queue entry.
REQ-018 Acceptance order within a cycle SHALL be data side first, instruction side second; a data-side write in that cycle SHALL be visible to a same-cycle instruction read of the same line.
REQ-019 Writes SHALL update storage at the rising edge of acceptance, consume no queue entry and produce no response.
REQ-020 A read whose line address and rec_dst match a valid queue entry SHALL be merged (not enqueued, not counted as dropped).
REQ-021 Up to two entries SHALL be enqueued per cycle; if free entries < needed, the data side takes the free entry and the unplaced request is dropped and drop_count incremented.
REQ-022 Each entry SHALL carry an age counter started at 0 on acceptance; the queue head SHALL be issued when its age >= MEM_LATENCY-1 so rec_en rises exactly MEM_LATENCY cycles after acceptance absent contention.
REQ-023 At most one response per cycle; responses in acceptance order; an entry matured behind an unissued head SHALL wait, issuing one per cycle thereafter.
REQ-024 Dequeue and enqueue in the same cycle SHALL be allowed; the freed entry is usable that cycle (full queue plus issuing head accepts one request).
REQ-025 queue_full SHALL be combinational: all QUEUE_DEPTH entries valid and no issue this cycle.
REQ-026 rec_en, rec_addr, rec_cacheline, rec_dst SHALL be registered; when rec_en is 0 they hold their last values.
REQ-027 drop_count SHALL saturate at 255 and never wrap; two drops in one cycle add 2, saturating.
REQ-028 Queue pointers SHALL wrap modulo QUEUE_DEPTH; occupancy counter width log2(QUEUE_DEPTH)+1.

Reset
REQ-029 rst low SHALL asynchronously clear all queue valids, pointers and ages; rec_en, rec_addr, rec_cacheline, rec_dst, queue_full, drop_count SHALL be 0.
REQ-030 Storage contents SHALL NOT be reset; initial contents are loaded at elaboration only.
REQ-031 Reset mid-operation SHALL discard all outstanding reads with no response after release; requests during reset are ignored.

Verification
REQ-032 ireq_ren at addr 0x00104 in cycle 0, storage line 0x10 = L -> rec_en=1 in cycle 5, rec_addr=0x00100, rec_cacheline=L, rec_dst=0.
REQ-033 Same-cycle dreq_wen to 0x00200 (data W) and ireq_ren to 0x00208 -> icache response 5 cycles later carries W, rec_dst=0; no response for the write.
REQ-034 ireq_ren to 0x00300 on 3 consecutive cycles -> exactly one response, drop_count=0.
REQ-035 Fill 4 distinct reads in cycles 0-1 (two per cycle), then data+instruction reads in cycle 2 -> queue_full=1, both dropped, drop_count=2; responses cycles 5,6,7,8 in acceptance order.
REQ-036 Accept 2 reads, assert rst low in cycle 2 for one cycle -> rec_en stays 0 thereafter, all outputs 0 during reset.
REQ-037 300 dropped requests -> drop_count holds 255.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency line memory answering instruction and data read requests in order
module mem_responder #(
    parameter int PADDR_W     = 20,
    parameter int LINE_W      = 128,
    parameter int MEM_LINES   = 256,
    parameter int MEM_LATENCY = 5,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ireq_ren,
    input  logic [PADDR_W-1:0] ireq_addr,
    input  logic               dreq_ren,
    input  logic               dreq_wen,
    input  logic [PADDR_W-1:0] dreq_addr,
    input  logic [LINE_W-1:0]  dreq_wdata,
    output logic               rec_en,
    output logic [PADDR_W-1:0] rec_addr,
    output logic [LINE_W-1:0]  rec_cacheline,
    output logic               rec_dst,
    output logic               queue_full,
    output logic [7:0]         drop_count
);
    localparam int OFFSET_W = $clog2(LINE_W / 8);
    localparam int IDX_W    = $clog2(MEM_LINES);
    localparam int LA_W     = PADDR_W - OFFSET_W;
    localparam int PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam logic [3:0]       AGE_MAT = 4'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    logic [LINE_W-1:0]      mem [MEM_LINES];
    logic [QUEUE_DEPTH-1:0] q_valid;
    logic [QUEUE_DEPTH-1:0] q_dst;
    logic [3:0]             q_age  [QUEUE_DEPTH];
    logic [LA_W-1:0]        q_line [QUEUE_DEPTH];
    logic [LINE_W-1:0]      q_data [QUEUE_DEPTH];
    logic [PTR_W-1:0]       head, tail, i_slot;
    logic [CNT_W-1:0]       count, slots;

    logic [LA_W-1:0]   d_line, i_line;
    logic [IDX_W-1:0]  d_idx, i_idx;
    logic [LINE_W-1:0] d_rdata, i_rdata;
    logic              issue, d_hit, i_hit, d_need, i_need, d_enq, i_enq;
    logic [1:0]        n_drop;
    logic [8:0]        drop_sum;
    logic              unused_offset_bits;

    assign d_line  = dreq_addr[PADDR_W-1:OFFSET_W];
    assign i_line  = ireq_addr[PADDR_W-1:OFFSET_W];
    assign d_idx   = dreq_addr[OFFSET_W +: IDX_W];
    assign i_idx   = ireq_addr[OFFSET_W +: IDX_W];
    assign unused_offset_bits = ^{dreq_addr[OFFSET_W-1:0], ireq_addr[OFFSET_W-1:0]};

    // Same-cycle data write forwards into an instruction read of the same storage line.
    assign d_rdata = mem[d_idx];
    assign i_rdata = (dreq_wen && d_idx == i_idx) ? dreq_wdata : mem[i_idx];

    assign issue      = q_valid[head] && (q_age[head] >= AGE_MAT);
    assign queue_full = (count == DEPTH_C) && !issue;
    assign i_slot     = tail + PTR_W'(d_enq);
    assign drop_sum   = {1'b0, drop_count} + {7'd0, n_drop};

    always_comb begin
        d_hit = 1'b0;
        i_hit = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (q_valid[i] && q_dst[i] && q_line[i] == d_line)
                d_hit = 1'b1;
            if (q_valid[i] && !q_dst[i] && q_line[i] == i_line)
                i_hit = 1'b1;
        end
        d_need = dreq_ren && !d_hit;
        i_need = ireq_ren && !i_hit;
        // The issuing head frees its slot for this cycle's requests; data side claims first.
        slots  = DEPTH_C - count + CNT_W'(issue);
        d_enq  = d_need && (slots != '0);
        i_enq  = i_need && (slots > (d_enq ? CNT_W'(1) : CNT_W'(0)));
        n_drop = 2'(d_need && !d_enq) + 2'(i_need && !i_enq);
    end

    always_ff @(posedge clk) begin
        if (rst && dreq_wen)
            mem[d_idx] <= dreq_wdata;
    end

    always_ff @(posedge clk) begin
        if (d_enq) begin
            q_line[tail] <= d_line;
            q_data[tail] <= d_rdata;
            q_dst[tail]  <= 1'b1;
        end
        if (i_enq) begin
            q_line[i_slot] <= i_line;
            q_data[i_slot] <= i_rdata;
            q_dst[i_slot]  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid       <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++)
                q_age[i] <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            rec_en        <= 1'b0;
            rec_addr      <= '0;
            rec_cacheline <= '0;
            rec_dst       <= 1'b0;
            drop_count    <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++)
                if (q_valid[i] && q_age[i] != 4'hF)
                    q_age[i] <= q_age[i] + 4'd1;
            rec_en <= issue;
            if (issue) begin
                rec_addr      <= {q_line[head], {OFFSET_W{1'b0}}};
                rec_cacheline <= q_data[head];
                rec_dst       <= q_dst[head];
                q_valid[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            // Enqueue follows dequeue so a slot freed this cycle can be refilled.
            if (d_enq) begin
                q_valid[tail] <= 1'b1;
                q_age[tail]   <= '0;
            end
            if (i_enq) begin
                q_valid[i_slot] <= 1'b1;
                q_age[i_slot]   <= '0;
            end
            tail       <= tail + PTR_W'(d_enq) + PTR_W'(i_enq);
            count      <= count + CNT_W'(d_enq) + CNT_W'(i_enq) - CNT_W'(issue);
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against a timestamped queue model
module tb_mem_responder;
    localparam int LAT   = 5;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ireq_ren = 1'b0, dreq_ren = 1'b0, dreq_wen = 1'b0;
    logic [19:0]  ireq_addr = '0, dreq_addr = '0;
    logic [127:0] dreq_wdata = '0;
    logic         rec_en, rec_dst, queue_full;
    logic [19:0]  rec_addr;
    logic [127:0] rec_cacheline;
    logic [7:0]   drop_count;

    mem_responder #(.PADDR_W(20), .LINE_W(128), .MEM_LINES(256),
                    .MEM_LATENCY(LAT), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ireq_ren(ireq_ren), .ireq_addr(ireq_addr),
        .dreq_ren(dreq_ren), .dreq_wen(dreq_wen), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
        .rec_en(rec_en), .rec_addr(rec_addr), .rec_cacheline(rec_cacheline), .rec_dst(rec_dst),
        .queue_full(queue_full), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0]  line;
        logic [127:0] data;
        bit           dst;
        int           acc;
    } ent_t;

    ent_t         mq[$];
    logic [127:0] mm [256];
    int           edge_n = 0;
    int           errors = 0;
    int           checks = 0;
    logic         e_en = 0, e_dst = 0, e_full = 0;
    logic [19:0]  e_addr = '0;
    logic [127:0] e_line = '0;
    int           e_drop = 0;

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, sample 1 time unit later.
    task automatic cycle(input bit dr, input bit dw, input logic [19:0] da, input logic [127:0] dwd,
                         input bit ir, input logic [19:0] ia);
        int free, nd;
        bit iss, dhit, ihit;
        logic [127:0] dd, id;
        logic [19:0] dl, il;
        ent_t e;
        dreq_ren = dr; dreq_wen = dw; dreq_addr = da; dreq_wdata = dwd;
        ireq_ren = ir; ireq_addr = ia;
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            e_en = 0; e_dst = 0; e_addr = '0; e_line = '0; e_drop = 0;
        end else begin
            iss = mq.size() > 0 && (edge_n - mq[0].acc >= LAT);
            dl = {da[19:4], 4'h0};
            il = {ia[19:4], 4'h0};
            dhit = 0; ihit = 0;
            foreach (mq[k]) begin
                if (mq[k].dst && mq[k].line == dl) dhit = 1;
                if (!mq[k].dst && mq[k].line == il) ihit = 1;
            end
            dd = mm[da[11:4]];
            id = (dw && da[11:4] == ia[11:4]) ? dwd : mm[ia[11:4]];
            if (dw) mm[da[11:4]] = dwd;
            free = DEPTH - mq.size() + (iss ? 1 : 0);
            e_en = iss;
            if (iss) begin
                e_addr = mq[0].line; e_line = mq[0].data; e_dst = mq[0].dst;
                void'(mq.pop_front());
            end
            nd = 0;
            if (dr && !dhit) begin
                if (free > 0) begin
                    e.line = dl; e.data = dd; e.dst = 1; e.acc = edge_n;
                    mq.push_back(e); free--;
                end else nd++;
            end
            if (ir && !ihit) begin
                if (free > 0) begin
                    e.line = il; e.data = id; e.dst = 0; e.acc = edge_n;
                    mq.push_back(e); free--;
                end else nd++;
            end
            e_drop = (e_drop + nd > 255) ? 255 : e_drop + nd;
        end
        edge_n++;
        e_full = mq.size() == DEPTH && (edge_n - mq[0].acc < LAT);
        #1;
        dreq_ren = 0; dreq_wen = 0; ireq_ren = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, '0, '0, 1, 20'h00040);
            checks++;
            if ({rec_en, rec_dst, rec_addr, rec_cacheline, queue_full, drop_count} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got en=%b dst=%b addr=%h full=%b drops=%0d, want all zero",
                         rec_en, rec_dst, rec_addr, queue_full, drop_count);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 256; i++) cycle(0, 1, 20'(i << 4), rnd_line(), 0, '0);
    endtask

    task automatic test_latency();
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) cycle(0, 0, '0, '0, 1, 20'h00104);
            else        cycle(0, 0, '0, '0, 0, '0);
            checks++;
            if ({rec_en, rec_dst, rec_addr, rec_cacheline} !== {e_en, e_dst, e_addr, e_line}) begin
                errors++;
                $display("FAIL latency_rsp k=%0d: got %h want %h", k,
                         {rec_en, rec_dst, rec_addr, rec_cacheline}, {e_en, e_dst, e_addr, e_line});
            end
            if (k == 5) begin
                checks++;
                if (rec_en !== 1'b1 || rec_addr !== 20'h00100 || rec_cacheline !== mm[8'h10] || rec_dst !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_fixed: got en=%b addr=%h dst=%b, want en=1 addr=00100 dst=0",
                             rec_en, rec_addr, rec_dst);
                end
            end
        end
    endtask

    task automatic test_write_fwd();
        logic [127:0] w;
        int n_rsp;
        w = rnd_line();
        n_rsp = 0;
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) cycle(0, 1, 20'h00200, w, 1, 20'h00208);
            else        cycle(0, 0, '0, '0, 0, '0);
            if (rec_en === 1'b1) n_rsp++;
            if (k == 5) begin
                checks++;
                if (rec_en !== 1'b1 || rec_cacheline !== w || rec_dst !== 1'b0 || rec_addr !== 20'h00200) begin
                    errors++;
                    $display("FAIL wfwd_rsp: got en=%b dst=%b addr=%h line=%h, want en=1 dst=0 addr=00200 line=%h",
                             rec_en, rec_dst, rec_addr, rec_cacheline, w);
                end
            end
        end
        checks++;
        if (n_rsp != 1) begin
            errors++;
            $display("FAIL wfwd_count: got %0d responses, want 1", n_rsp);
        end
        for (int k = 0; k <= 5; k++) begin
            if (k == 0) cycle(1, 0, 20'h00200, '0, 0, '0);
            else        cycle(0, 0, '0, '0, 0, '0);
        end
        checks++;
        if (rec_en !== 1'b1 || rec_cacheline !== w || rec_dst !== 1'b1) begin
            errors++;
            $display("FAIL wfwd_readback: got en=%b dst=%b line=%h, want en=1 dst=1 line=%h",
                     rec_en, rec_dst, rec_cacheline, w);
        end
    endtask

    task automatic test_merge();
        int n_rsp;
        n_rsp = 0;
        for (int k = 0; k < 11; k++) begin
            if (k < 3) cycle(0, 0, '0, '0, 1, 20'h00300);
            else       cycle(0, 0, '0, '0, 0, '0);
            if (rec_en === 1'b1) n_rsp++;
            checks++;
            if ({rec_en, rec_dst, rec_addr, rec_cacheline} !== {e_en, e_dst, e_addr, e_line}) begin
                errors++;
                $display("FAIL merge_rsp k=%0d: got %h want %h", k,
                         {rec_en, rec_dst, rec_addr, rec_cacheline}, {e_en, e_dst, e_addr, e_line});
            end
        end
        checks++;
        if (n_rsp != 1 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL merge_count: got %0d responses drops=%0d, want 1 responses drops=0", n_rsp, drop_count);
        end
    endtask

    task automatic test_full();
        logic [19:0] want_a [4];
        logic        want_d [4];
        want_a[0] = 20'h00400; want_a[1] = 20'h00410; want_a[2] = 20'h00420; want_a[3] = 20'h00430;
        want_d[0] = 1'b1; want_d[1] = 1'b0; want_d[2] = 1'b1; want_d[3] = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            case (k)
                0: cycle(1, 0, 20'h00400, '0, 1, 20'h00410);
                1: cycle(1, 0, 20'h00420, '0, 1, 20'h00430);
                2: cycle(1, 0, 20'h00440, '0, 1, 20'h00450);
                default: cycle(0, 0, '0, '0, 0, '0);
            endcase
            if (k == 1) begin
                checks++;
                if (queue_full !== 1'b1) begin
                    errors++;
                    $display("FAIL full_flag: got queue_full=%b, want 1", queue_full);
                end
            end
            if (k == 2) begin
                checks++;
                if (drop_count !== 8'd2) begin
                    errors++;
                    $display("FAIL full_drops: got drop_count=%0d, want 2", drop_count);
                end
            end
            if (k >= 5 && k <= 8) begin
                checks++;
                if (rec_en !== 1'b1 || rec_addr !== want_a[k-5] || rec_dst !== want_d[k-5]) begin
                    errors++;
                    $display("FAIL full_order k=%0d: got en=%b addr=%h dst=%b, want en=1 addr=%h dst=%b",
                             k, rec_en, rec_addr, rec_dst, want_a[k-5], want_d[k-5]);
                end
            end
            checks++;
            if ({rec_en, rec_dst, rec_addr, rec_cacheline, queue_full} !== {e_en, e_dst, e_addr, e_line, e_full}) begin
                errors++;
                $display("FAIL full_model k=%0d: got %h want %h", k,
                         {rec_en, rec_dst, rec_addr, rec_cacheline, queue_full}, {e_en, e_dst, e_addr, e_line, e_full});
            end
        end
    endtask

    task automatic test_random();
        bit dr, dw, ir;
        logic [19:0] da, ia;
        for (int k = 0; k < 400; k++) begin
            dw = ($urandom_range(0, 7) == 0);
            dr = !dw && ($urandom_range(0, 2) != 0);
            ir = ($urandom_range(0, 2) != 0);
            da = 20'(($urandom_range(0, 1) << 12) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
            ia = 20'(($urandom_range(0, 1) << 12) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
            cycle(dr, dw, da, rnd_line(), ir, ia);
            checks++;
            if ({rec_en, rec_dst, rec_addr, rec_cacheline} !== {e_en, e_dst, e_addr, e_line}) begin
                errors++;
                $display("FAIL rand_rsp k=%0d: got %h want %h", k,
                         {rec_en, rec_dst, rec_addr, rec_cacheline}, {e_en, e_dst, e_addr, e_line});
            end
            checks++;
            if (queue_full !== e_full || drop_count !== 8'(e_drop)) begin
                errors++;
                $display("FAIL rand_status k=%0d: got full=%b drops=%0d want full=%b drops=%0d",
                         k, queue_full, drop_count, e_full, e_drop);
            end
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 350; k++) begin
            cycle(1, 0, 20'((2 * k) << 4) ^ 20'h80000, '0, 1, 20'((2 * k + 1) << 4) ^ 20'h80000);
            checks++;
            if (drop_count !== 8'(e_drop) || rec_en !== e_en) begin
                errors++;
                $display("FAIL sat_track k=%0d: got drops=%0d en=%b want drops=%0d en=%b",
                         k, drop_count, rec_en, e_drop, e_en);
            end
        end
        checks++;
        if (drop_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_final: got drop_count=%0d, want 255", drop_count);
        end
    endtask

    task automatic test_reset_mid();
        int n_rsp;
        idle(8);
        cycle(1, 0, 20'h00500, '0, 1, 20'h00510);
        cycle(0, 0, '0, '0, 0, '0);
        rst = 1'b0;
        #1;
        checks++;
        if ({rec_en, rec_dst, rec_addr, rec_cacheline, queue_full, drop_count} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got en=%b addr=%h full=%b drops=%0d, want all zero",
                     rec_en, rec_addr, queue_full, drop_count);
        end
        cycle(1, 0, 20'h00520, '0, 1, 20'h00530);
        rst = 1'b1;
        n_rsp = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, '0, '0, 0, '0);
            if (rec_en !== 1'b0) n_rsp++;
        end
        checks++;
        if (n_rsp != 0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d responses drops=%0d, want 0 and 0", n_rsp, drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        idle(8);
        test_write_fwd();
        idle(8);
        test_merge();
        idle(8);
        test_full();
        idle(8);
        test_random();
        idle(8);
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
